mem_access_stage: RTL

Memory-stage access unit: consumes the EX/MEM pipeline register outputs, performs loads and stores over a req/ack data-memory handshake, stalls the upstream pipeline while an access is outstanding, and registers the results toward write-back (MEM/WB). It sits between the EX/MEM register and the WB stage. Non-memory instructions pass through in one cycle.

---
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-stage access unit: issues loads/stores over a req/ack data-memory port,
// stalls upstream while an access is outstanding and registers results into MEM/WB.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemWrite_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] ReadData_o,
  output logic        err_o
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, alu_lat_q, alu_lat_d;
  logic          we_q, we_d, rw_lat_q, rw_lat_d, m2r_lat_q, m2r_lat_d;
  logic [4:0]    rd_lat_q, rd_lat_d;
  logic          req_q, req_d, err_q, err_d;
  logic          wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;
  logic          stall_c;

  logic access, misaligned, timeout;
  assign access     = MemToReg_i | MemWrite_i;
  assign misaligned = |ALUResult_i[1:0];
  assign timeout    = (cnt_q == CW'(MAX_WAIT - 1));

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      alu_lat_q  <= '0;
      we_q       <= 1'b0;
      rw_lat_q   <= 1'b0;
      m2r_lat_q  <= 1'b0;
      rd_lat_q   <= '0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_m2r_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_alu_q   <= '0;
      wb_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      alu_lat_q  <= alu_lat_d;
      we_q       <= we_d;
      rw_lat_q   <= rw_lat_d;
      m2r_lat_q  <= m2r_lat_d;
      rd_lat_q   <= rd_lat_d;
      req_q      <= req_d;
      err_q      <= err_d;
      wb_rw_q    <= wb_rw_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rd_q    <= wb_rd_d;
      wb_alu_q   <= wb_alu_d;
      wb_rdata_q <= wb_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access && !misaligned) state_d = BUSY;
      BUSY:    if (mem_ack_i || timeout)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic; MEM/WB defaults to a bubble
  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    alu_lat_d  = alu_lat_q;
    we_d       = we_q;
    rw_lat_d   = rw_lat_q;
    m2r_lat_d  = m2r_lat_q;
    rd_lat_d   = rd_lat_q;
    req_d      = 1'b0;
    err_d      = 1'b0;
    wb_rw_d    = 1'b0;
    wb_m2r_d   = 1'b0;
    wb_rd_d    = '0;
    wb_alu_d   = '0;
    wb_rdata_d = '0;
    stall_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!access) begin
          wb_rw_d  = RegWrite_i;
          wb_m2r_d = MemToReg_i;
          wb_rd_d  = RDaddr_i;
          wb_alu_d = ALUResult_i;
        end else if (misaligned) begin
          err_d = 1'b1;
        end else begin
          // A store never writes the register file even if MemToReg_i is also set
          stall_c   = 1'b1;
          req_d     = 1'b1;
          cnt_d     = '0;
          addr_d    = ALUResult_i;
          alu_lat_d = ALUResult_i;
          wdata_d   = RDData_i;
          we_d      = MemWrite_i;
          rd_lat_d  = RDaddr_i;
          rw_lat_d  = RegWrite_i & ~MemWrite_i;
          m2r_lat_d = MemToReg_i & ~MemWrite_i;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          wb_rw_d    = rw_lat_q;
          wb_m2r_d   = m2r_lat_q;
          wb_rd_d    = rd_lat_q;
          wb_alu_d   = alu_lat_q;
          wb_rdata_d = we_q ? 32'h0 : mem_rdata_i;
        end else if (timeout) begin
          err_d = 1'b1;
        end else begin
          stall_c = 1'b1;
          req_d   = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign stall_o     = stall_c & ~rst_i;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign RegWrite_o  = wb_rw_q;
  assign MemToReg_o  = wb_m2r_q;
  assign RDaddr_o    = wb_rd_q;
  assign ALUResult_o = wb_alu_q;
  assign ReadData_o  = wb_rdata_q;
  assign err_o       = err_q;

endmodule
